// File: rtl/d16_wb_arbiter.sv
// d16_wb_arbiter: two-master Wishbone arbiter for the shared d16 memory/IO bus.
// Master 0 is the CPU and master 1 is a secondary master such as DMA or a debug loader.
// Grants are round-robin, and the owner keeps the bus for as long as it holds cyc high.
// Only the owner receives ack/err, and read data is broadcast to both masters.
// Optional feature: define D16_ARB_TIMEOUT_EN to add a bus watchdog. It raises err on the
// owner after TIMEOUT consecutive cycles with no slave response.
module d16_wb_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_m0_cyc,
  input  logic          i_m0_we,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [DW-1:0] i_m0_dat,
  output logic [DW-1:0] o_m0_dat,
  output logic          o_m0_ack,
  output logic          o_m0_err,
  input  logic          i_m1_cyc,
  input  logic          i_m1_we,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m1_dat,
  output logic [DW-1:0] o_m1_dat,
  output logic          o_m1_ack,
  output logic          o_m1_err,
  output logic          o_s_cyc,
  output logic          o_s_we,
  output logic [AW-1:0] o_s_addr,
  output logic [DW-1:0] o_s_dat,
  input  logic [DW-1:0] i_s_dat,
  input  logic          i_s_ack,
  input  logic          i_s_err,
  output logic [1:0]    o_grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS0 = 2'd1,
    BUS1 = 2'd2
  } state_t;

  state_t state, state_next;
  logic   last, last_next;   // most recently granted master
  logic   owner_cyc;         // cyc of the current owner, 0 in IDLE
  logic   tmo_hit;           // watchdog expiry for the current cycle

  assign owner_cyc = (state == BUS0) ? i_m0_cyc :
                     (state == BUS1) ? i_m1_cyc : 1'b0;

  // State and round-robin pointer register.
  // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      last  <= 1'b1;   // makes master 0 win the first tie
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  // Next-state logic: arbitrate in IDLE, and hand over directly when the owner drops cyc.
  // NOTE: the defaults at the top of the block keep combinational logic from inferring latches.
  always_comb begin
    state_next = state;
    last_next  = last;
    unique case (state)
      IDLE: begin
        if (i_m0_cyc && (!i_m1_cyc || last)) state_next = BUS0;
        else if (i_m1_cyc)                   state_next = BUS1;
      end
      BUS0: if (!i_m0_cyc) state_next = i_m1_cyc ? BUS1 : IDLE;
      BUS1: if (!i_m1_cyc) state_next = i_m0_cyc ? BUS0 : IDLE;
      default: state_next = IDLE;
    endcase
    if (state_next != state) begin
      if (state_next == BUS0) last_next = 1'b0;
      if (state_next == BUS1) last_next = 1'b1;
    end
  end

`ifdef D16_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt;
  logic          wd_wait;

  // Owner is mid-cycle and the slave has not answered this cycle.
  assign wd_wait = owner_cyc && !i_s_ack && !i_s_err;
  // Expire on the TIMEOUT-th consecutive unanswered cycle.
  assign tmo_hit = wd_wait && (wd_cnt == CW'(TIMEOUT - 1));

  // Watchdog counter: it restarts on any response, cyc low, expiry or ownership change.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                                     wd_cnt <= '0;
    else if (!wd_wait || tmo_hit || state_next != state) wd_cnt <= '0;
    else                                                wd_cnt <= wd_cnt + 1'b1;
  end
`else
  localparam int timeout_unused = TIMEOUT;
  assign tmo_hit = 1'b0;
`endif

  // Output mux: forward the owner's request to the slave, and route the response back to the owner only.
  always_comb begin
    o_s_cyc  = 1'b0;
    o_s_we   = 1'b0;
    o_s_addr = '0;
    o_s_dat  = '0;
    o_grant  = 2'b00;
    o_m0_ack = 1'b0;
    o_m0_err = 1'b0;
    o_m1_ack = 1'b0;
    o_m1_err = 1'b0;
    o_m0_dat = i_s_dat;
    o_m1_dat = i_s_dat;
    unique case (state)
      BUS0: begin
        o_s_cyc  = i_m0_cyc;
        o_s_we   = i_m0_we & i_m0_cyc;
        o_s_addr = i_m0_addr;
        o_s_dat  = i_m0_dat;
        o_grant  = 2'b01;
        o_m0_ack = i_s_ack & ~i_s_err & i_m0_cyc;
        o_m0_err = (i_s_err | tmo_hit) & i_m0_cyc;
      end
      BUS1: begin
        o_s_cyc  = i_m1_cyc;
        o_s_we   = i_m1_we & i_m1_cyc;
        o_s_addr = i_m1_addr;
        o_s_dat  = i_m1_dat;
        o_grant  = 2'b10;
        o_m1_ack = i_s_ack & ~i_s_err & i_m1_cyc;
        o_m1_err = (i_s_err | tmo_hit) & i_m1_cyc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_d16_wb_arbiter.sv
// tb_d16_wb_arbiter: directed, self-checking bench for d16_wb_arbiter.
// Inputs change 1 ns after the rising edge, and outputs are sampled on the falling edge.
module tb_d16_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_we, m1_cyc, m1_we;
  logic [15:0] m0_addr, m0_wdat, m1_addr, m1_wdat;
  logic [15:0] m0_rdat, m1_rdat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_we;
  logic [15:0] s_addr, s_wdat, s_rdat;
  logic        s_ack, s_err;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  d16_wb_arbiter #(.AW(16), .DW(16), .TIMEOUT(15)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_m0_cyc(m0_cyc), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_dat(m0_wdat),
    .o_m0_dat(m0_rdat), .o_m0_ack(m0_ack), .o_m0_err(m0_err),
    .i_m1_cyc(m1_cyc), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_dat(m1_wdat),
    .o_m1_dat(m1_rdat), .o_m1_ack(m1_ack), .o_m1_err(m1_err),
    .o_s_cyc(s_cyc), .o_s_we(s_we), .o_s_addr(s_addr), .o_s_dat(s_wdat),
    .i_s_dat(s_rdat), .i_s_ack(s_ack), .i_s_err(s_err),
    .o_grant(grant)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    m0_cyc = 0; m0_we = 0; m0_addr = '0; m0_wdat = '0;
    m1_cyc = 0; m1_we = 0; m1_addr = '0; m1_wdat = '0;
    s_rdat = '0; s_ack = 0; s_err = 0;
    #12 rst_n = 1'b1;

    // Reset state
    settle;
    check("rst_grant", grant, 2'b00);
    check("rst_s_cyc", s_cyc, 0);
    check("rst_s_addr", s_addr, 0);

    // Single master read with one-cycle arbitration latency
    tick; m0_cyc = 1; m0_addr = 16'h0010;
    settle; check("t1_latency_s_cyc", s_cyc, 0);
    tick;
    settle;
    check("t1_s_cyc", s_cyc, 1);
    check("t1_grant", grant, 2'b01);
    check("t1_s_addr", s_addr, 16'h0010);
    check("t1_s_we", s_we, 0);
    tick; s_ack = 1; s_rdat = 16'hBEEF;
    settle;
    check("t1_m0_ack", m0_ack, 1);
    check("t1_m0_dat", m0_rdat, 16'hBEEF);
    check("t1_m1_ack", m1_ack, 0);
    tick; s_ack = 0; m0_cyc = 0;
    tick;
    settle; check("t1_idle_grant", grant, 2'b00);

    // Tie after reset: m0 wins, then a direct handover to m1, then the next tie goes to m0
    rst_n = 1'b0; #1 rst_n = 1'b1;
    tick; m0_cyc = 1; m1_cyc = 1;
    settle; check("t2_idle", grant, 2'b00);
    tick;
    settle;
    check("t2_tie_grant", grant, 2'b01);
    check("t2_tie_s_cyc", s_cyc, 1);
    tick; s_ack = 1;
    settle;
    check("t2_owner_ack", m0_ack, 1);
    check("t2_waiter_ack", m1_ack, 0);
    tick; s_ack = 0; m0_cyc = 0;
    settle;
    check("t2_release_s_cyc", s_cyc, 0);
    check("t2_release_grant", grant, 2'b01);
    tick;
    settle;
    check("t2_handover_grant", grant, 2'b10);
    check("t2_handover_s_cyc", s_cyc, 1);
    tick; m1_cyc = 0;
    tick;
    settle; check("t2_back_idle", grant, 2'b00);
    tick; m0_cyc = 1; m1_cyc = 1;
    tick;
    settle; check("t2_rr_tie_grant", grant, 2'b01);

    // Lock: m1 does three writes while m0 waits
    tick; m0_cyc = 0; m1_cyc = 0;
    tick; m1_cyc = 1; m1_we = 1; m1_addr = 16'h0100; m1_wdat = 16'hA000;
    tick; m0_cyc = 1; m0_addr = 16'h0200; m0_we = 0;
    for (int b = 0; b < 3; b++) begin
      m1_addr = 16'h0100 + 16'(b);
      m1_wdat = 16'hA000 + 16'(b);
      s_ack = 1;
      settle;
      check("t3_lock_grant", grant, 2'b10);
      check("t3_lock_addr", s_addr, 32'h0100 + b);
      check("t3_lock_wdat", s_wdat, 32'hA000 + b);
      check("t3_lock_we", s_we, 1);
      check("t3_lock_m1_ack", m1_ack, 1);
      check("t3_lock_m0_ack", m0_ack, 0);
      tick;
    end
    m1_cyc = 0; m1_we = 0; s_ack = 0;
    settle;
    check("t3_release_grant", grant, 2'b10);
    check("t3_release_we", s_we, 0);
    tick;
    settle;
    check("t3_m0_grant", grant, 2'b01);
    check("t3_m0_addr", s_addr, 16'h0200);

    // Err priority, and responses ignored while cyc is low or in IDLE
    tick; s_ack = 1; s_err = 1;
    settle;
    check("t4_err", m0_err, 1);
    check("t4_ack_suppressed", m0_ack, 0);
    check("t4_other_err", m1_err, 0);
    tick; s_err = 0; m0_cyc = 0;
    settle; check("t4_cyc_low_ack", m0_ack, 0);
    tick;
    settle;
    check("t4_idle_ack0", m0_ack, 0);
    check("t4_idle_ack1", m1_ack, 0);
    s_ack = 0;

    // Reset mid-transfer drops outputs without a clock
    tick; m1_cyc = 1; m1_we = 1;
    tick;
    settle;
    check("t5_pre_grant", grant, 2'b10);
    check("t5_pre_s_cyc", s_cyc, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_s_cyc", s_cyc, 0);
    check("t5_rst_grant", grant, 2'b00);
    check("t5_rst_s_we", s_we, 0);
    #1 rst_n = 1'b1; m0_cyc = 1;
    tick;
    settle; check("t5_post_tie_grant", grant, 2'b01);

    // Watchdog: m0 is left without a slave response
    tick; m0_cyc = 0; m1_cyc = 0; m1_we = 0;
    tick; m0_cyc = 1;
    tick;
    for (int k = 1; k <= 45; k++) begin
      settle;
`ifdef D16_ARB_TIMEOUT_EN
      check("t6_tmo_err", m0_err, (k % 15 == 0) ? 1 : 0);
`else
      check("t6_no_err", m0_err, 0);
`endif
      tick;
    end
    m0_cyc = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
